// File: rtl/iob_cache_perf_ctrl_pkg.sv
// Shared definitions for the cache performance/control block:
// CSR word map, CTRL/STATUS bit positions and invalidate FSM encoding.
package iob_cache_perf_ctrl_pkg;

    localparam int unsigned ADDR_RW_HIT     = 0;
    localparam int unsigned ADDR_RW_MISS    = 1;
    localparam int unsigned ADDR_READ_HIT   = 2;
    localparam int unsigned ADDR_READ_MISS  = 3;
    localparam int unsigned ADDR_WRITE_HIT  = 4;
    localparam int unsigned ADDR_WRITE_MISS = 5;
    localparam int unsigned ADDR_CTRL       = 6;
    localparam int unsigned ADDR_STATUS     = 7;
    localparam int unsigned ADDR_VERSION    = 8;

    localparam int unsigned CTRL_RST_CNT = 0;
    localparam int unsigned CTRL_FREEZE  = 1;
    localparam int unsigned CTRL_INV     = 2;
    localparam int unsigned CTRL_W       = 3;

    localparam int unsigned STAT_WTB_EMPTY = 0;
    localparam int unsigned STAT_WTB_FULL  = 1;
    localparam int unsigned STAT_INV_BUSY  = 2;
    localparam int unsigned STAT_OVF       = 3;
    localparam int unsigned STAT_FROZEN    = 4;

    // Counter slots inside the top-level counter array
    localparam int unsigned CNT_RD_HIT  = 0;
    localparam int unsigned CNT_RD_MISS = 1;
    localparam int unsigned CNT_WR_HIT  = 2;
    localparam int unsigned CNT_WR_MISS = 3;
    localparam int unsigned NUM_CNT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_INV   = 2'd2
    } inv_state_e;

endpackage

// File: rtl/iob_cache_perf_cnt.sv
// Single event counter: wrap-around or saturating, synchronous clear,
// enable gate, and a same-cycle overflow pulse.
module iob_cache_perf_cnt
    import iob_cache_perf_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] value_o,
    output logic             ovf_c_o
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;
    logic             at_max_c;
    logic             bump_c;

    assign at_max_c = &value_q;
    // Clear beats a coincident increment, so that event is dropped
    assign bump_c   = inc_i & en_i & ~clr_i;
    assign ovf_c_o  = bump_c & at_max_c;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (bump_c) begin
            if (at_max_c) begin
                value_d = (SATURATE != 0) ? value_q : '0;
            end else begin
                value_d = value_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/iob_cache_perf_ctrl.sv
// Cache control/status CSR block: hit/miss performance counters with
// freeze/clear/overflow, and a drain-then-invalidate handshake to the core.
module iob_cache_perf_ctrl
    import iob_cache_perf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned SATURATE = 0,
    parameter logic [15:0] VERSION  = 16'h0100
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              valid_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ready_o,
    input  logic              wtbuf_empty_i,
    input  logic              wtbuf_full_i,
    input  logic              read_hit_i,
    input  logic              read_miss_i,
    input  logic              write_hit_i,
    input  logic              write_miss_i,
    output logic              invalidate_o,
    input  logic              invalidate_ack_i
);

    localparam int unsigned SUM_W = CNT_W + 1;

    inv_state_e        state_q, state_d;
    logic              inv_q, inv_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              frozen_q, frozen_d;
    logic              ovf_q, ovf_d;

    logic              ctrl_wr_c;
    logic              clr_c;
    logic              inv_start_c;
    logic [NUM_CNT-1:0] event_c;
    logic [NUM_CNT-1:0] ovf_pulse_c;
    logic [CNT_W-1:0]  cnt_c [NUM_CNT];
    logic [SUM_W-1:0]  hit_sum_c, miss_sum_c;
    logic [CNT_W-1:0]  rw_hit_c, rw_miss_c;
    logic [DATA_W-1:0] rd_val_c;
    logic [DATA_W-1-CTRL_W:0] unused_wdata;

    assign unused_wdata = wdata_i[DATA_W-1:CTRL_W];

    assign ctrl_wr_c   = valid_i & we_i & (addr_i == ADDR_W'(ADDR_CTRL));
    assign clr_c       = ctrl_wr_c & wdata_i[CTRL_RST_CNT];
    assign inv_start_c = ctrl_wr_c & wdata_i[CTRL_INV];

    assign event_c[CNT_RD_HIT]  = read_hit_i;
    assign event_c[CNT_RD_MISS] = read_miss_i;
    assign event_c[CNT_WR_HIT]  = write_hit_i;
    assign event_c[CNT_WR_MISS] = write_miss_i;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        iob_cache_perf_cnt #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .inc_i    (event_c[g]),
            .clr_i    (clr_c),
            .en_i     (~frozen_q),
            .value_o  (cnt_c[g]),
            .ovf_c_o  (ovf_pulse_c[g])
        );
    end

    // Aggregate counts are formed one bit wider so saturation can see the carry
    assign hit_sum_c  = {1'b0, cnt_c[CNT_RD_HIT]}  + {1'b0, cnt_c[CNT_WR_HIT]};
    assign miss_sum_c = {1'b0, cnt_c[CNT_RD_MISS]} + {1'b0, cnt_c[CNT_WR_MISS]};
    assign rw_hit_c   = ((SATURATE != 0) && hit_sum_c[CNT_W])  ? '1 : hit_sum_c[CNT_W-1:0];
    assign rw_miss_c  = ((SATURATE != 0) && miss_sum_c[CNT_W]) ? '1 : miss_sum_c[CNT_W-1:0];

    always_comb begin
        rd_val_c = '0;
        case (addr_i)
            ADDR_W'(ADDR_RW_HIT):     rd_val_c = DATA_W'(rw_hit_c);
            ADDR_W'(ADDR_RW_MISS):    rd_val_c = DATA_W'(rw_miss_c);
            ADDR_W'(ADDR_READ_HIT):   rd_val_c = DATA_W'(cnt_c[CNT_RD_HIT]);
            ADDR_W'(ADDR_READ_MISS):  rd_val_c = DATA_W'(cnt_c[CNT_RD_MISS]);
            ADDR_W'(ADDR_WRITE_HIT):  rd_val_c = DATA_W'(cnt_c[CNT_WR_HIT]);
            ADDR_W'(ADDR_WRITE_MISS): rd_val_c = DATA_W'(cnt_c[CNT_WR_MISS]);
            ADDR_W'(ADDR_STATUS): begin
                rd_val_c[STAT_WTB_EMPTY] = wtbuf_empty_i;
                rd_val_c[STAT_WTB_FULL]  = wtbuf_full_i;
                rd_val_c[STAT_INV_BUSY]  = (state_q != ST_IDLE);
                rd_val_c[STAT_OVF]       = ovf_q;
                rd_val_c[STAT_FROZEN]    = frozen_q;
            end
            ADDR_W'(ADDR_VERSION):    rd_val_c = DATA_W'(VERSION);
            default:                  rd_val_c = '0;
        endcase
    end

    // CSR response and control flags
    always_comb begin
        ready_d  = valid_i;
        rdata_d  = (valid_i && !we_i) ? rd_val_c : '0;
        frozen_d = ctrl_wr_c ? wdata_i[CTRL_FREEZE] : frozen_q;
        ovf_d    = clr_c ? 1'b0 : (ovf_q | (|ovf_pulse_c));
    end

    // Invalidate sequencer next state; invalidate_o tracks the INV state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (inv_start_c)      state_d = ST_DRAIN;
            ST_DRAIN: if (wtbuf_empty_i)    state_d = ST_INV;
            ST_INV:   if (invalidate_ack_i) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
        inv_d = (state_d == ST_INV);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= ST_IDLE;
            inv_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            frozen_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inv_q    <= inv_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            frozen_q <= frozen_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign ready_o      = ready_q;
    assign invalidate_o = inv_q;

endmodule

// File: tb/tb_iob_cache_perf_ctrl.sv
// Bench for iob_cache_perf_ctrl: a 32-bit wrapping instance plus 4-bit
// wrapping and saturating instances share one CSR bus and event inputs.
module tb_iob_cache_perf_ctrl;

    logic        clk;
    logic        arst_n_i;
    logic        valid_i, we_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic        wtbuf_empty_i, wtbuf_full_i;
    logic        read_hit_i, read_miss_i, write_hit_i, write_miss_i;
    logic        invalidate_ack_i;

    logic [31:0] rdata0, rdataw, rdatas;
    logic        ready0, readyw, readys;
    logic        inv0, invw, invs;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] ew;
        logic [31:0] es;
        logic [2:0]  m;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];

    iob_cache_perf_ctrl dut (
        .clk_i(clk), .arst_n_i(arst_n_i), .valid_i(valid_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata0), .ready_o(ready0),
        .wtbuf_empty_i(wtbuf_empty_i), .wtbuf_full_i(wtbuf_full_i),
        .read_hit_i(read_hit_i), .read_miss_i(read_miss_i),
        .write_hit_i(write_hit_i), .write_miss_i(write_miss_i),
        .invalidate_o(inv0), .invalidate_ack_i(invalidate_ack_i)
    );

    iob_cache_perf_ctrl #(.CNT_W(4), .SATURATE(0)) dut_w (
        .clk_i(clk), .arst_n_i(arst_n_i), .valid_i(valid_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdataw), .ready_o(readyw),
        .wtbuf_empty_i(wtbuf_empty_i), .wtbuf_full_i(wtbuf_full_i),
        .read_hit_i(read_hit_i), .read_miss_i(read_miss_i),
        .write_hit_i(write_hit_i), .write_miss_i(write_miss_i),
        .invalidate_o(invw), .invalidate_ack_i(invalidate_ack_i)
    );

    iob_cache_perf_ctrl #(.CNT_W(4), .SATURATE(1)) dut_s (
        .clk_i(clk), .arst_n_i(arst_n_i), .valid_i(valid_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdatas), .ready_o(readys),
        .wtbuf_empty_i(wtbuf_empty_i), .wtbuf_full_i(wtbuf_full_i),
        .read_hit_i(read_hit_i), .read_miss_i(read_miss_i),
        .write_hit_i(write_hit_i), .write_miss_i(write_miss_i),
        .invalidate_o(invs), .invalidate_ack_i(invalidate_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers: all called just after a falling edge, return after the next one
    task automatic csr_rd(input int a, input logic [31:0] e0, input logic [31:0] ew,
                          input logic [31:0] es, input logic [2:0] m, input string nm);
        exp_t x;
        x.e0 = e0; x.ew = ew; x.es = es; x.m = m;
        sb_q.push_back(x);
        nm_q.push_back(nm);
        valid_i = 1'b1; we_i = 1'b0; addr_i = 4'(a); wdata_i = '0;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic csr_wr(input int a, input logic [31:0] d);
        exp_t x;
        x.e0 = '0; x.ew = '0; x.es = '0; x.m = 3'b111;
        sb_q.push_back(x);
        nm_q.push_back("write_rdata_zero");
        valid_i = 1'b1; we_i = 1'b1; addr_i = 4'(a); wdata_i = d;
        @(negedge clk);
        valid_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic ev(input logic rh, input logic rm, input logic wh, input logic wm, input int n);
        read_hit_i = rh; read_miss_i = rm; write_hit_i = wh; write_miss_i = wm;
        repeat (n) @(negedge clk);
        read_hit_i = 1'b0; read_miss_i = 1'b0; write_hit_i = 1'b0; write_miss_i = 1'b0;
    endtask

    // Scoreboard consumer: ready timing and read data on every acknowledged request
    task automatic monitor();
        logic v;
        exp_t x;
        string nm;
        forever begin
            @(posedge clk);
            v = valid_i;
            @(negedge clk);
            if (arst_n_i) begin
                if (v || ready0) begin
                    vectors++;
                    if (ready0 !== v) begin
                        errors++;
                        $display("FAIL ready_timing: ready_o=%b, valid last cycle=%b", ready0, v);
                    end
                end
                if (ready0 === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL scoreboard_underflow: ready_o with no pending request");
                    end else begin
                        x  = sb_q.pop_front();
                        nm = nm_q.pop_front();
                        if (x.m[0]) begin
                            vectors++;
                            if (rdata0 !== x.e0) begin
                                errors++;
                                $display("FAIL %s (32b wrap): got %h want %h", nm, rdata0, x.e0);
                            end
                        end
                        if (x.m[1]) begin
                            vectors++;
                            if (rdataw !== x.ew) begin
                                errors++;
                                $display("FAIL %s (4b wrap): got %h want %h", nm, rdataw, x.ew);
                            end
                        end
                        if (x.m[2]) begin
                            vectors++;
                            if (rdatas !== x.es) begin
                                errors++;
                                $display("FAIL %s (4b sat): got %h want %h", nm, rdatas, x.es);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready0, inv0, rdata0} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b inv=%b rdata=%h want all 0", ready0, inv0, rdata0);
        end
        arst_n_i = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 6; a++) csr_rd(a, 32'd0, 32'd0, 32'd0, 3'b111, "reset_counter");
        csr_rd(6, 32'd0, 32'd0, 32'd0, 3'b111, "ctrl_reads_zero");
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "reset_status");
        csr_rd(8, 32'h100, 32'h100, 32'h100, 3'b111, "version");
        csr_rd(9, 32'd0, 32'd0, 32'd0, 3'b111, "unmapped_zero");
    endtask

    task automatic test_counting();
        ev(1'b1, 1'b0, 1'b0, 1'b1, 5);
        ev(1'b0, 1'b1, 1'b0, 1'b0, 3);
        csr_rd(2, 32'd5, 32'd5, 32'd5, 3'b111, "read_hit");
        csr_rd(5, 32'd5, 32'd5, 32'd5, 3'b111, "write_miss");
        csr_rd(3, 32'd3, 32'd3, 32'd3, 3'b111, "read_miss");
        csr_rd(0, 32'd5, 32'd5, 32'd5, 3'b111, "rw_hit");
        csr_rd(1, 32'd8, 32'd8, 32'd8, 3'b111, "rw_miss");
        csr_rd(4, 32'd0, 32'd0, 32'd0, 3'b111, "write_hit_idle");
        csr_wr(2, 32'h77);
        csr_rd(2, 32'd5, 32'd5, 32'd5, 3'b111, "ro_write_ignored");
        read_hit_i = 1'b1;
        csr_rd(2, 32'd5, 32'd5, 32'd5, 3'b111, "read_before_inc");
        read_hit_i = 1'b0;
        csr_rd(2, 32'd6, 32'd6, 32'd6, 3'b111, "read_after_inc");
        csr_rd(0, 32'd6, 32'd6, 32'd6, 3'b111, "rw_hit_after_inc");
    endtask

    task automatic test_overflow();
        csr_wr(6, 32'h1);
        ev(1'b0, 1'b0, 1'b1, 1'b0, 17);
        csr_rd(4, 32'd17, 32'd1, 32'd15, 3'b111, "write_hit_ovf");
        csr_rd(7, 32'h1, 32'h9, 32'h9, 3'b111, "status_ovf");
        csr_rd(0, 32'd17, 32'd1, 32'd15, 3'b111, "rw_hit_ovf");
        ev(1'b1, 1'b0, 1'b0, 1'b0, 15);
        csr_rd(2, 32'd15, 32'd15, 32'd15, 3'b111, "read_hit_max");
        csr_rd(0, 32'd32, 32'd0, 32'd15, 3'b111, "rw_hit_trunc_clamp");
        csr_wr(6, 32'h1);
        csr_rd(4, 32'd0, 32'd0, 32'd0, 3'b111, "write_hit_cleared");
        csr_rd(2, 32'd0, 32'd0, 32'd0, 3'b111, "read_hit_cleared");
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "status_ovf_cleared");
    endtask

    task automatic test_freeze();
        csr_wr(6, 32'h2);
        ev(1'b1, 1'b0, 1'b0, 1'b0, 4);
        csr_rd(2, 32'd0, 32'd0, 32'd0, 3'b111, "frozen_hold");
        csr_rd(7, 32'h11, 32'h11, 32'h11, 3'b111, "status_frozen");
        csr_wr(6, 32'h0);
        ev(1'b1, 1'b0, 1'b0, 1'b0, 1);
        csr_rd(2, 32'd1, 32'd1, 32'd1, 3'b111, "unfrozen_count");
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "status_unfrozen");
        read_hit_i = 1'b1;
        csr_wr(6, 32'h1);
        read_hit_i = 1'b0;
        csr_rd(2, 32'd0, 32'd0, 32'd0, 3'b111, "clear_beats_event");
    endtask

    task automatic test_invalidate();
        wtbuf_empty_i = 1'b0;
        wtbuf_full_i  = 1'b1;
        csr_rd(7, 32'h2, 32'h2, 32'h2, 3'b111, "status_full");
        wtbuf_full_i  = 1'b0;
        csr_wr(6, 32'h4);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (inv0 !== 1'b0) begin
                errors++;
                $display("FAIL drain_inv_low cycle %0d: got %b want 0", i, inv0);
            end
            csr_rd(7, 32'h4, 32'h4, 32'h4, 3'b111, "status_draining");
        end
        csr_wr(6, 32'h4);
        wtbuf_empty_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (inv0 !== 1'b1) begin
            errors++;
            $display("FAIL inv_rise: got %b want 1", inv0);
        end
        csr_wr(6, 32'h4);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (inv0 !== 1'b1) begin
                errors++;
                $display("FAIL inv_held cycle %0d: got %b want 1", i, inv0);
            end
            csr_rd(7, 32'h5, 32'h5, 32'h5, 3'b111, "status_inv");
        end
        invalidate_ack_i = 1'b1;
        @(negedge clk);
        invalidate_ack_i = 1'b0;
        vectors++;
        if (inv0 !== 1'b0) begin
            errors++;
            $display("FAIL inv_drop_on_ack: got %b want 0", inv0);
        end
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "status_idle_after_ack");
        invalidate_ack_i = 1'b1;
        @(negedge clk);
        invalidate_ack_i = 1'b0;
        vectors++;
        if (inv0 !== 1'b0) begin
            errors++;
            $display("FAIL ack_in_idle: got %b want 0", inv0);
        end
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "status_ack_in_idle");
    endtask

    task automatic test_reset_mid_inv();
        ev(1'b0, 1'b0, 1'b1, 1'b1, 2);
        csr_rd(4, 32'd2, 32'd2, 32'd2, 3'b111, "write_hit_pre_reset");
        csr_rd(5, 32'd2, 32'd2, 32'd2, 3'b111, "write_miss_pre_reset");
        csr_wr(6, 32'h4);
        @(negedge clk);
        vectors++;
        if (inv0 !== 1'b1) begin
            errors++;
            $display("FAIL inv_before_reset: got %b want 1", inv0);
        end
        #2 arst_n_i = 1'b0;
        #1;
        vectors++;
        if ({inv0, ready0, rdata0} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: inv=%b ready=%b rdata=%h want all 0", inv0, ready0, rdata0);
        end
        @(negedge clk);
        arst_n_i = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 6; a++) csr_rd(a, 32'd0, 32'd0, 32'd0, 3'b111, "counter_after_reset");
        csr_rd(7, 32'h1, 32'h1, 32'h1, 3'b111, "status_after_reset");
        vectors++;
        if (inv0 !== 1'b0) begin
            errors++;
            $display("FAIL inv_after_reset: got %b want 0", inv0);
        end
    endtask

    initial begin
        arst_n_i = 1'b0;
        valid_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        wtbuf_empty_i = 1'b1; wtbuf_full_i = 1'b0;
        read_hit_i = 1'b0; read_miss_i = 1'b0; write_hit_i = 1'b0; write_miss_i = 1'b0;
        invalidate_ack_i = 1'b0;
        fork
            monitor();
        join_none

        test_reset();
        test_counting();
        test_overflow();
        test_freeze();
        test_invalidate();
        test_reset_mid_inv();

        repeat (2) @(negedge clk);
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
